// File: rtl/latch_bank_pkg.sv
// Shared types and helpers for the latch bank write scheduler.
// Optional feature macro: LATCH_BANK_CLEAR_EN (adds the CLEAR state).
package latch_bank_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_ENABLE = 3'd2,
    ST_HOLD   = 3'd3,
    ST_CLEAR  = 3'd4
  } state_t;

  localparam int DEF_NREQ   = 4;
  localparam int DEF_DW     = 8;
  localparam int DEF_AW     = 3;
  localparam int DEF_EN_CYC = 1;

  // Widest address the decode helper handles; callers truncate the result.
  localparam int MAX_AW = 8;
  localparam int MAX_EN = 1 << MAX_AW;

  // One-hot decode of a latch entry address.
  function automatic logic [MAX_EN-1:0] addr_onehot(input logic [MAX_AW-1:0] addr);
    return MAX_EN'(1) << addr;
  endfunction

endpackage

// File: rtl/latch_bank_write_sched_rr_arbiter.sv
// Combinational round-robin picker: first set request at or above ptr,
// wrapping modulo NREQ (NREQ need not be a power of two).
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [PW-1:0]   winner,
  output logic            valid
);

  logic [NREQ-1:0] rot;
  logic [PW-1:0]   off;
  logic [PW:0]     sum;

  // Rotate requests so ptr sits at bit 0, take the lowest set bit, rotate back.
  always_comb begin
    rot   = NREQ'({req, req} >> ptr);
    valid = 1'b0;
    off   = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (rot[i]) begin
        valid = 1'b1;
        off   = PW'(i);
      end
    end
    sum = {1'b0, ptr} + {1'b0, off};
    if (sum >= (PW+1)'(NREQ)) begin
      sum = sum - (PW+1)'(NREQ);
    end
    winner = sum[PW-1:0];
  end

endmodule

// File: rtl/latch_bank_write_sched.sv
// Write scheduler for a bank of enable-gated D latches. Arbitrates NREQ
// requesters round-robin and sequences each write as setup / enable pulse /
// hold so D and address are stable around both latch enable edges.
// Optional feature macro: LATCH_BANK_CLEAR_EN adds clr_req/clr_done and a
// CLEAR state that pulses lat_rstn low for EN_CYC cycles.
//
// state  | meaning
// IDLE   | waiting; arbitrates req (or clr_req) every cycle
// SETUP  | lat_data driven with captured data, enables off
// ENABLE | one-hot enable on captured entry for EN_CYC cycles
// HOLD   | enables off, data held, done pulse, advance rr_ptr
// CLEAR  | lat_rstn low for EN_CYC cycles (clear feature only)
module latch_bank_write_sched
  import latch_bank_pkg::*;
#(
  parameter int NREQ   = DEF_NREQ,
  parameter int DW     = DEF_DW,
  parameter int AW     = DEF_AW,
  parameter int EN_CYC = DEF_EN_CYC
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*AW-1:0]   req_addr,
  input  logic [NREQ*DW-1:0]   req_data,
  output logic [NREQ-1:0]      gnt,
  output logic [NREQ-1:0]      done,
  output logic                 busy,
  output logic [DW-1:0]        lat_data,
  output logic [(1<<AW)-1:0]   lat_en,
  output logic                 lat_rstn
`ifdef LATCH_BANK_CLEAR_EN
  ,
  input  logic                 clr_req,
  output logic                 clr_done
`endif
);

  localparam int NE = 1 << AW;
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = (EN_CYC > 1) ? $clog2(EN_CYC) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(EN_CYC - 1);

  state_t        state;
  logic [PW-1:0] rr_ptr;
  logic [PW-1:0] win;
  logic [AW-1:0] cap_addr;
  logic [CW-1:0] cnt;

  logic [PW-1:0] arb_winner;
  logic          arb_valid;

  rr_arbiter #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_arb (
    .req    (req),
    .ptr    (rr_ptr),
    .winner (arb_winner),
    .valid  (arb_valid)
  );

  // Sequencer: every output is a register updated alongside the state.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state    <= ST_IDLE;
      rr_ptr   <= '0;
      win      <= '0;
      cap_addr <= '0;
      cnt      <= '0;
      gnt      <= '0;
      done     <= '0;
      busy     <= 1'b0;
      lat_data <= '0;
      lat_en   <= '0;
      lat_rstn <= 1'b0;
`ifdef LATCH_BANK_CLEAR_EN
      clr_done <= 1'b0;
`endif
    end else begin
      gnt      <= '0;
      done     <= '0;
      lat_rstn <= 1'b1;
`ifdef LATCH_BANK_CLEAR_EN
      clr_done <= 1'b0;
`endif
      case (state)
        ST_IDLE: begin
`ifdef LATCH_BANK_CLEAR_EN
          if (clr_req) begin
            state    <= ST_CLEAR;
            busy     <= 1'b1;
            lat_rstn <= 1'b0;
            cnt      <= CNT_LOAD;
          end else
`endif
          if (arb_valid) begin
            state    <= ST_SETUP;
            busy     <= 1'b1;
            win      <= arb_winner;
            gnt      <= NREQ'(1) << arb_winner;
            cap_addr <= req_addr[arb_winner*AW +: AW];
            // Data is captured straight into the D register so it is
            // already stable during the SETUP cycle.
            lat_data <= req_data[arb_winner*DW +: DW];
          end
        end
        ST_SETUP: begin
          state  <= ST_ENABLE;
          lat_en <= NE'(addr_onehot(MAX_AW'(cap_addr)));
          cnt    <= CNT_LOAD;
        end
        ST_ENABLE: begin
          if (cnt == '0) begin
            state  <= ST_HOLD;
            lat_en <= '0;
            done   <= NREQ'(1) << win;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_HOLD: begin
          state  <= ST_IDLE;
          busy   <= 1'b0;
          rr_ptr <= (win == PW'(NREQ - 1)) ? '0 : win + 1'b1;
        end
`ifdef LATCH_BANK_CLEAR_EN
        ST_CLEAR: begin
          if (cnt == '0) begin
            state    <= ST_IDLE;
            busy     <= 1'b0;
            clr_done <= 1'b1;
          end else begin
            cnt      <= cnt - 1'b1;
            lat_rstn <= 1'b0;
          end
        end
`endif
        default: begin
          state  <= ST_IDLE;
          busy   <= 1'b0;
          lat_en <= '0;
        end
      endcase
    end
  end

endmodule
